// File: rtl/rs_issue_queue_pkg.sv
// rtl/rs_issue_queue_pkg.sv - shared op encodings and width defaults for the reservation station
// Purpose: op enum (OP_NOP is the idle/reset encoding) and default widths used by
//          rs_issue_queue and rs_issue_queue_select.
// Ports:   none (package).
package rs_issue_queue_pkg;

  localparam int RS_OP_W   = 6;
  localparam int RS_ROB_W  = 4;
  localparam int RS_DATA_W = 32;
  localparam int RS_ADDR_W = 32;

  typedef enum logic [RS_OP_W-1:0] {
    OP_NOP  = 6'd0,
    OP_ADD  = 6'd1,
    OP_SUB  = 6'd2,
    OP_AND  = 6'd3,
    OP_OR   = 6'd4,
    OP_XOR  = 6'd5,
    OP_SLL  = 6'd6,
    OP_SRL  = 6'd7,
    OP_SRA  = 6'd8,
    OP_SLT  = 6'd9,
    OP_SLTU = 6'd10
  } rs_op_e;

endpackage

// File: rtl/rs_issue_queue_select.sv
// rtl/rs_issue_queue_select.sv - picks one ready entry (one-hot grant)
// Purpose: combinational select. With RS_AGE_ORDER_EN defined the oldest ready entry
//          wins using the age matrix; otherwise the lowest-index ready entry wins.
// Ports:   ready_in  - per-entry candidate vector
//          age_in    - age matrix, row i bit j set when entry j is older than i (RS_AGE_ORDER_EN only)
//          grant_out - one-hot selected entry
//          found_out - at least one candidate exists
module rs_issue_queue_select #(
  parameter int RS_DEPTH = 16
) (
  input  logic [RS_DEPTH-1:0]               ready_in,
`ifdef RS_AGE_ORDER_EN
  input  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_in,
`endif
  output logic [RS_DEPTH-1:0]               grant_out,
  output logic                              found_out
);

  always_comb begin
    grant_out = '0;
`ifdef RS_AGE_ORDER_EN
    // Ages form a strict order over valid entries, so exactly one ready entry has
    // no older ready entry.
    for (int i = 0; i < RS_DEPTH; i++) begin
      grant_out[i] = ready_in[i] && ((age_in[i] & ready_in) == '0);
    end
`else
    // Descending scan: the last hit, i.e. the lowest index, is kept.
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (ready_in[i]) begin
        grant_out    = '0;
        grant_out[i] = 1'b1;
      end
    end
`endif
  end

  assign found_out = |ready_in;

endmodule

// File: rtl/rs_issue_queue.sv
// rtl/rs_issue_queue.sv - reservation station holding ALU ops until both operands are ready
// Purpose: dispatch into the lowest free entry (with same-cycle CDB bypass), operand wakeup
//          from NUM_CDB broadcast channels, one issue per cycle into a registered
//          valid/ready output stage. Optional macro RS_AGE_ORDER_EN selects oldest-first issue.
// Ports:   clk_in, rst_in (sync, active low), rdy_in (low freezes all state), flush_in
//          disp_*   - dispatch request and payload; full_out back-pressures it
//          cdb_*    - broadcast channels, channel k at [k*W +: W]
//          iss_*    - registered issue stage, handshake with iss_ready_in
//          count_out - occupied entries
module rs_issue_queue
  import rs_issue_queue_pkg::*;
#(
  parameter int RS_DEPTH = 16,
  parameter int NUM_CDB  = 2,
  parameter int DATA_W   = RS_DATA_W,
  parameter int ADDR_W   = RS_ADDR_W,
  parameter int OP_W     = RS_OP_W,
  parameter int ROB_W    = RS_ROB_W
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        flush_in,
  input  logic                        disp_valid_in,
  input  logic [OP_W-1:0]             disp_op_in,
  input  logic [DATA_W-1:0]           disp_v1_in,
  input  logic [DATA_W-1:0]           disp_v2_in,
  input  logic                        disp_r1_in,
  input  logic                        disp_r2_in,
  input  logic [ROB_W-1:0]            disp_q1_in,
  input  logic [ROB_W-1:0]            disp_q2_in,
  input  logic [DATA_W-1:0]           disp_imm_in,
  input  logic [ADDR_W-1:0]           disp_pc_in,
  input  logic [ROB_W-1:0]            disp_rob_in,
  output logic                        full_out,
  input  logic [NUM_CDB-1:0]          cdb_valid_in,
  input  logic [NUM_CDB*ROB_W-1:0]    cdb_tag_in,
  input  logic [NUM_CDB*DATA_W-1:0]   cdb_data_in,
  output logic                        iss_valid_out,
  input  logic                        iss_ready_in,
  output logic [OP_W-1:0]             iss_op_out,
  output logic [DATA_W-1:0]           iss_v1_out,
  output logic [DATA_W-1:0]           iss_v2_out,
  output logic [DATA_W-1:0]           iss_imm_out,
  output logic [ADDR_W-1:0]           iss_pc_out,
  output logic [ROB_W-1:0]            iss_rob_out,
  output logic [$clog2(RS_DEPTH):0]   count_out
);

  localparam int CNT_W = $clog2(RS_DEPTH) + 1;

  logic [RS_DEPTH-1:0] valid_q, valid_d, r1_q, r1_d, r2_q, r2_d;
  logic [OP_W-1:0]     op_q  [RS_DEPTH], op_d  [RS_DEPTH];
  logic [DATA_W-1:0]   v1_q  [RS_DEPTH], v1_d  [RS_DEPTH];
  logic [DATA_W-1:0]   v2_q  [RS_DEPTH], v2_d  [RS_DEPTH];
  logic [DATA_W-1:0]   imm_q [RS_DEPTH], imm_d [RS_DEPTH];
  logic [ADDR_W-1:0]   pc_q  [RS_DEPTH], pc_d  [RS_DEPTH];
  logic [ROB_W-1:0]    q1_q  [RS_DEPTH], q1_d  [RS_DEPTH];
  logic [ROB_W-1:0]    q2_q  [RS_DEPTH], q2_d  [RS_DEPTH];
  logic [ROB_W-1:0]    rob_q [RS_DEPTH], rob_d [RS_DEPTH];

  logic                iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]     iss_op_q, iss_op_d;
  logic [DATA_W-1:0]   iss_v1_q, iss_v1_d, iss_v2_q, iss_v2_d, iss_imm_q, iss_imm_d;
  logic [ADDR_W-1:0]   iss_pc_q, iss_pc_d;
  logic [ROB_W-1:0]    iss_rob_q, iss_rob_d;
  logic [CNT_W-1:0]    count_q, count_d;

  logic [RS_DEPTH-1:0] ready_vec, grant, free_oh;
  logic                found, accept, load;
  logic [DATA_W-1:0]   byp_v1, byp_v2;
  logic                byp_r1, byp_r2;

`ifdef RS_AGE_ORDER_EN
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q, age_d;
`endif

  // Only state from before this edge counts, so a same-cycle wakeup issues next cycle.
  assign ready_vec = valid_q & r1_q & r2_q;

  rs_issue_queue_select #(.RS_DEPTH(RS_DEPTH)) u_select (
    .ready_in  (ready_vec),
`ifdef RS_AGE_ORDER_EN
    .age_in    (age_q),
`endif
    .grant_out (grant),
    .found_out (found)
  );

  assign full_out = (count_q == CNT_W'(RS_DEPTH));
  assign accept   = disp_valid_in && !full_out;
  assign load     = found && (!iss_valid_q || iss_ready_in);

  always_comb begin
    // Lowest-index free slot (descending scan keeps the last hit).
    free_oh = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end

    // Dispatch bypass: descending channel scan so the lowest channel wins.
    byp_v1 = disp_v1_in;
    byp_r1 = disp_r1_in;
    byp_v2 = disp_v2_in;
    byp_r2 = disp_r2_in;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_valid_in[k] && !disp_r1_in && cdb_tag_in[k*ROB_W +: ROB_W] == disp_q1_in) begin
        byp_v1 = cdb_data_in[k*DATA_W +: DATA_W];
        byp_r1 = 1'b1;
      end
      if (cdb_valid_in[k] && !disp_r2_in && cdb_tag_in[k*ROB_W +: ROB_W] == disp_q2_in) begin
        byp_v2 = cdb_data_in[k*DATA_W +: DATA_W];
        byp_r2 = 1'b1;
      end
    end
  end

  always_comb begin
    valid_d = valid_q;  r1_d  = r1_q;  r2_d = r2_q;
    op_d    = op_q;     v1_d  = v1_q;  v2_d = v2_q;
    imm_d   = imm_q;    pc_d  = pc_q;  q1_d = q1_q;
    q2_d    = q2_q;     rob_d = rob_q;
    iss_valid_d = iss_valid_q;
    iss_op_d    = iss_op_q;
    iss_v1_d    = iss_v1_q;
    iss_v2_d    = iss_v2_q;
    iss_imm_d   = iss_imm_q;
    iss_pc_d    = iss_pc_q;
    iss_rob_d   = iss_rob_q;
    count_d     = count_q + CNT_W'(accept) - CNT_W'(load);
`ifdef RS_AGE_ORDER_EN
    age_d       = age_q;
`endif

    // Wakeup of resident operands, lowest channel wins.
    for (int i = 0; i < RS_DEPTH; i++) begin
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (cdb_valid_in[k] && valid_q[i] && !r1_q[i] && cdb_tag_in[k*ROB_W +: ROB_W] == q1_q[i]) begin
          v1_d[i] = cdb_data_in[k*DATA_W +: DATA_W];
          r1_d[i] = 1'b1;
        end
        if (cdb_valid_in[k] && valid_q[i] && !r2_q[i] && cdb_tag_in[k*ROB_W +: ROB_W] == q2_q[i]) begin
          v2_d[i] = cdb_data_in[k*DATA_W +: DATA_W];
          r2_d[i] = 1'b1;
        end
      end
    end

    // Dispatch write. Runs before the free below so a freed column is still
    // cleared from the new entry's age row.
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (accept && free_oh[i]) begin
        valid_d[i] = 1'b1;
        op_d[i]    = disp_op_in;
        v1_d[i]    = byp_v1;
        r1_d[i]    = byp_r1;
        v2_d[i]    = byp_v2;
        r2_d[i]    = byp_r2;
        q1_d[i]    = disp_q1_in;
        q2_d[i]    = disp_q2_in;
        imm_d[i]   = disp_imm_in;
        pc_d[i]    = disp_pc_in;
        rob_d[i]   = disp_rob_in;
`ifdef RS_AGE_ORDER_EN
        age_d[i]   = valid_q;
`endif
      end
    end

    // Issue stage load / drain.
    if (load) begin
      iss_valid_d = 1'b1;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (grant[i]) begin
          iss_op_d   = op_q[i];
          iss_v1_d   = v1_q[i];
          iss_v2_d   = v2_q[i];
          iss_imm_d  = imm_q[i];
          iss_pc_d   = pc_q[i];
          iss_rob_d  = rob_q[i];
          valid_d[i] = 1'b0;
`ifdef RS_AGE_ORDER_EN
          for (int j = 0; j < RS_DEPTH; j++) begin
            age_d[j][i] = 1'b0;
          end
`endif
        end
      end
    end else if (iss_ready_in) begin
      iss_valid_d = 1'b0;
    end

    if (flush_in) begin
      valid_d     = '0;
      iss_valid_d = 1'b0;
      iss_op_d    = OP_W'(OP_NOP);
      iss_v1_d    = '0;
      iss_v2_d    = '0;
      iss_imm_d   = '0;
      iss_pc_d    = '0;
      iss_rob_d   = '0;
      count_d     = '0;
`ifdef RS_AGE_ORDER_EN
      age_d       = '0;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      valid_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_op_q    <= OP_W'(OP_NOP);
      iss_v1_q    <= '0;
      iss_v2_q    <= '0;
      iss_imm_q   <= '0;
      iss_pc_q    <= '0;
      iss_rob_q   <= '0;
      count_q     <= '0;
`ifdef RS_AGE_ORDER_EN
      age_q       <= '0;
`endif
    end else if (rdy_in) begin
      valid_q     <= valid_d;
      iss_valid_q <= iss_valid_d;
      iss_op_q    <= iss_op_d;
      iss_v1_q    <= iss_v1_d;
      iss_v2_q    <= iss_v2_d;
      iss_imm_q   <= iss_imm_d;
      iss_pc_q    <= iss_pc_d;
      iss_rob_q   <= iss_rob_d;
      count_q     <= count_d;
`ifdef RS_AGE_ORDER_EN
      age_q       <= age_d;
`endif
    end
  end

  // Entry payload needs no reset: it is only observed behind valid_q.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      r1_q  <= r1_d;   r2_q  <= r2_d;
      op_q  <= op_d;   v1_q  <= v1_d;   v2_q <= v2_d;
      imm_q <= imm_d;  pc_q  <= pc_d;
      q1_q  <= q1_d;   q2_q  <= q2_d;   rob_q <= rob_d;
    end
  end

  assign iss_valid_out = iss_valid_q;
  assign iss_op_out    = iss_op_q;
  assign iss_v1_out    = iss_v1_q;
  assign iss_v2_out    = iss_v2_q;
  assign iss_imm_out   = iss_imm_q;
  assign iss_pc_out    = iss_pc_q;
  assign iss_rob_out   = iss_rob_q;
  assign count_out     = count_q;

endmodule
